csr_int_ctrl: RTL and testbench

CSR_INT_CTRL -- requirements
Module: csr_int_ctrl

---
 rtl/csr_int_ctrl_if.sv | 24 ++
 rtl/csr_int_ctrl.sv | 137 +++++++++++++
 tb/tb_csr_int_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_int_ctrl_if.sv
// CSR access port for csr_int_ctrl: a WB-stage masked write strobe and a
// combinational read port.
interface csr_int_ctrl_if;
  // Write semantics: csr_we is a one-cycle qualified strobe with no ready.
  // While csr_we=1 the fields addr/wdata/wmask are valid and the write is
  // always accepted at the next rising clock edge. The read port is purely
  // combinational: csr_rdata follows csr_raddr and the current register state.
  logic        csr_we;
  logic [13:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_wmask;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;

  modport master (
    output csr_we, csr_addr, csr_wdata, csr_wmask, csr_raddr,
    input  csr_rdata
  );

  modport slave (
    input  csr_we, csr_addr, csr_wdata, csr_wmask, csr_raddr,
    output csr_rdata
  );
endinterface

// File: rtl/csr_int_ctrl.sv
// Interrupt/timer CSR block: ECFG, ESTAT, TID, TCFG, TVAL, TICLR, with a
// countdown timer feeding ESTAT.IS[11] and a combinational has_int output.
module csr_int_ctrl #(
  parameter logic [31:0] TID_RST = 32'h0
) (
  input  logic                clk,
  input  logic                resetn,
  csr_int_ctrl_if.slave       csr,
  input  logic                wb_ex,
  input  logic [5:0]          wb_ecode,
  input  logic [8:0]          wb_esubcode,
  input  logic [7:0]          hw_int_in,
  input  logic                ipi_int_in,
  input  logic                crmd_ie,
  output logic [1:0]          csr_ecfg_lie_soft,
  output logic                has_int
);

  localparam logic [13:0] ADDR_ECFG  = 14'h0004;
  localparam logic [13:0] ADDR_ESTAT = 14'h0005;
  localparam logic [13:0] ADDR_TID   = 14'h0040;
  localparam logic [13:0] ADDR_TCFG  = 14'h0041;
  localparam logic [13:0] ADDR_TVAL  = 14'h0042;
  localparam logic [13:0] ADDR_TICLR = 14'h0044;
  localparam logic [12:0] ECFG_WMASK = 13'h1BFF;

  logic [12:0] ecfg_lie;
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_timer;
  logic        is_ipi;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [31:0] tid;
  logic [31:0] tcfg;
  logic [31:0] tval;
  logic        armed;

  logic        we_ecfg, we_estat, we_tid, we_tcfg, we_ticlr;
  logic [12:0] ecfg_new;
  logic [1:0]  is_sw_new;
  logic [31:0] tid_new;
  logic [31:0] tcfg_new;
  logic        ticlr_clr;
  logic        timer_expire;
  logic [31:0] ecfg_val;
  logic [31:0] estat_val;

  assign we_ecfg  = csr.csr_we && (csr.csr_addr == ADDR_ECFG);
  assign we_estat = csr.csr_we && (csr.csr_addr == ADDR_ESTAT);
  assign we_tid   = csr.csr_we && (csr.csr_addr == ADDR_TID);
  assign we_tcfg  = csr.csr_we && (csr.csr_addr == ADDR_TCFG);
  assign we_ticlr = csr.csr_we && (csr.csr_addr == ADDR_TICLR);

  // Masked merge, restricted afterwards to each register's writable bits.
  assign ecfg_new  = ((csr.csr_wdata[12:0] & csr.csr_wmask[12:0]) |
                      (ecfg_lie & ~csr.csr_wmask[12:0])) & ECFG_WMASK;
  assign is_sw_new = (csr.csr_wdata[1:0] & csr.csr_wmask[1:0]) |
                     (is_sw & ~csr.csr_wmask[1:0]);
  assign tid_new   = (csr.csr_wdata & csr.csr_wmask) | (tid & ~csr.csr_wmask);
  assign tcfg_new  = (csr.csr_wdata & csr.csr_wmask) | (tcfg & ~csr.csr_wmask);
  assign ticlr_clr = we_ticlr && csr.csr_wdata[0] && csr.csr_wmask[0];

  assign timer_expire = armed && (tval == 32'h0);

  assign ecfg_val  = {19'h0, ecfg_lie};
  assign estat_val = {1'b0, esubcode, ecode, 3'b000, is_ipi, is_timer, 1'b0,
                      is_hw, is_sw};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ecfg_lie <= '0;
      is_sw    <= '0;
      is_hw    <= '0;
      is_ipi   <= 1'b0;
      ecode    <= '0;
      esubcode <= '0;
      tid      <= TID_RST;
      tcfg     <= '0;
    end else begin
      is_hw  <= hw_int_in;
      is_ipi <= ipi_int_in;
      if (we_ecfg)  ecfg_lie <= ecfg_new;
      if (we_estat) is_sw    <= is_sw_new;
      if (we_tid)   tid      <= tid_new;
      if (we_tcfg)  tcfg     <= tcfg_new;
      if (wb_ex) begin
        ecode    <= wb_ecode;
        esubcode <= wb_esubcode;
      end
    end
  end

  // A TCFG write overrides reload/disarm, but an expiry in that cycle still
  // latches IS[11]; expiry also beats a simultaneous TICLR clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tval     <= '0;
      armed    <= 1'b0;
      is_timer <= 1'b0;
    end else begin
      if (we_tcfg) begin
        tval  <= {tcfg_new[31:2], 2'b00};
        armed <= tcfg_new[0];
      end else if (armed) begin
        if (tval != 32'h0) begin
          tval <= tval - 32'h1;
        end else if (tcfg[1]) begin
          tval <= {tcfg[31:2], 2'b00};
        end else begin
          armed <= 1'b0;
        end
      end
      if (timer_expire) begin
        is_timer <= 1'b1;
      end else if (ticlr_clr) begin
        is_timer <= 1'b0;
      end
    end
  end

  always_comb begin
    csr.csr_rdata = 32'h0;
    unique case (csr.csr_raddr)
      ADDR_ECFG:  csr.csr_rdata = ecfg_val;
      ADDR_ESTAT: csr.csr_rdata = estat_val;
      ADDR_TID:   csr.csr_rdata = tid;
      ADDR_TCFG:  csr.csr_rdata = tcfg;
      ADDR_TVAL:  csr.csr_rdata = tval;
      default:    csr.csr_rdata = 32'h0;
    endcase
  end

  assign has_int           = crmd_ie && (|(estat_val[12:0] & ecfg_lie));
  assign csr_ecfg_lie_soft = ecfg_lie[1:0];

endmodule

// File: tb/tb_csr_int_ctrl.sv
// Directed bench for csr_int_ctrl: a vector table for register/interrupt
// behaviour plus hand sequences for timer, exception and reset corner cases.
module tb_csr_int_ctrl;

  localparam logic [31:0] TID_RST = 32'h1234_5678;
  localparam logic [13:0] A_ECFG  = 14'h0004;
  localparam logic [13:0] A_ESTAT = 14'h0005;
  localparam logic [13:0] A_TID   = 14'h0040;
  localparam logic [13:0] A_TCFG  = 14'h0041;
  localparam logic [13:0] A_TVAL  = 14'h0042;
  localparam logic [13:0] A_TICLR = 14'h0044;

  logic        clk;
  logic        resetn;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        crmd_ie;
  logic [1:0]  csr_ecfg_lie_soft;
  logic        has_int;

  int checks;
  int failures;

  csr_int_ctrl_if csr ();

  csr_int_ctrl #(.TID_RST(TID_RST)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .csr               (csr),
    .wb_ex             (wb_ex),
    .wb_ecode          (wb_ecode),
    .wb_esubcode       (wb_esubcode),
    .hw_int_in         (hw_int_in),
    .ipi_int_in        (ipi_int_in),
    .crmd_ie           (crmd_ie),
    .csr_ecfg_lie_soft (csr_ecfg_lie_soft),
    .has_int           (has_int)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic [7:0]  hw;
    logic        ipi;
    logic        ie;
    logic [13:0] raddr;
    logic [31:0] exp_rdata;
    logic        exp_int;
    logic [1:0]  exp_lie;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic read_chk(input string name, input logic [13:0] addr, input logic [31:0] exp);
    csr.csr_raddr = addr;
    #1;
    check(name, csr.csr_rdata, exp);
  endtask

  task automatic read_bit_chk(input string name, input logic [13:0] addr, input int bitn,
                              input logic exp);
    logic [31:0] v;
    csr.csr_raddr = addr;
    #1;
    v = csr.csr_rdata;
    check(name, {31'h0, v[bitn]}, {31'h0, exp});
  endtask

  // Drives one write across a rising edge and leaves time at edge + 1.
  task automatic do_write(input logic [13:0] addr, input logic [31:0] wdata,
                          input logic [31:0] wmask);
    @(negedge clk);
    csr.csr_we    = 1'b1;
    csr.csr_addr  = addr;
    csr.csr_wdata = wdata;
    csr.csr_wmask = wmask;
    @(posedge clk);
    #1;
    csr.csr_we = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn        = 1'b0;
    csr.csr_we    = 1'b0;
    csr.csr_addr  = '0;
    csr.csr_wdata = '0;
    csr.csr_wmask = '0;
    csr.csr_raddr = '0;
    wb_ex         = 1'b0;
    wb_ecode      = '0;
    wb_esubcode   = '0;
    hw_int_in     = '0;
    ipi_int_in    = 1'b0;
    crmd_ie       = 1'b1;

    //         we    addr     wdata         wmask         hw     ipi   ie    raddr    exp_rdata     int   lie
    vecs[0]  = '{1'b1, A_ECFG,  32'h0000_0003, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b1, A_ECFG,  32'h0000_0003, 1'b0, 2'b11};
    vecs[1]  = '{1'b1, A_ESTAT, 32'h0000_0002, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b1, A_ESTAT, 32'h0000_0002, 1'b1, 2'b11};
    vecs[2]  = '{1'b1, A_ESTAT, 32'h0000_0000, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b1, A_ESTAT, 32'h0000_0000, 1'b0, 2'b11};
    vecs[3]  = '{1'b1, A_ECFG,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b1, A_ECFG,  32'h0000_1BFF, 1'b0, 2'b11};
    vecs[4]  = '{1'b1, A_ECFG,  32'h0000_0000, 32'h0000_0400, 8'h00, 1'b0, 1'b1, A_ECFG,  32'h0000_1BFF, 1'b0, 2'b11};
    vecs[5]  = '{1'b1, A_ECFG,  32'h0000_0000, 32'h0000_0003, 8'h00, 1'b0, 1'b1, A_ECFG,  32'h0000_1BFC, 1'b0, 2'b00};
    vecs[6]  = '{1'b1, A_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b1, A_ESTAT, 32'h0000_0003, 1'b0, 2'b00};
    vecs[7]  = '{1'b0, A_ECFG,  32'h0000_0000, 32'h0000_0000, 8'h01, 1'b0, 1'b1, A_ESTAT, 32'h0000_0007, 1'b1, 2'b00};
    vecs[8]  = '{1'b0, A_ECFG,  32'h0000_0000, 32'h0000_0000, 8'h01, 1'b0, 1'b0, A_ESTAT, 32'h0000_0007, 1'b0, 2'b00};
    vecs[9]  = '{1'b0, A_ECFG,  32'h0000_0000, 32'h0000_0000, 8'h00, 1'b1, 1'b1, A_ESTAT, 32'h0000_1003, 1'b1, 2'b00};
    vecs[10] = '{1'b1, A_TID,   32'hDEAD_BEEF, 32'hFFFF_0000, 8'h00, 1'b0, 1'b1, A_TID,   32'hDEAD_5678, 1'b0, 2'b00};
    vecs[11] = '{1'b1, A_TICLR, 32'h0000_0001, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b1, A_TICLR, 32'h0000_0000, 1'b0, 2'b00};
    vecs[12] = '{1'b0, A_ECFG,  32'h0000_0000, 32'h0000_0000, 8'h00, 1'b0, 1'b1, 14'h0043, 32'h0000_0000, 1'b0, 2'b00};
    vecs[13] = '{1'b1, A_TCFG,  32'hFFFF_FFF0, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b1, A_TCFG,  32'hFFFF_FFF0, 1'b0, 2'b00};
    vecs[14] = '{1'b0, A_ECFG,  32'h0000_0000, 32'h0000_0000, 8'h00, 1'b0, 1'b1, A_TVAL,  32'hFFFF_FFF0, 1'b0, 2'b00};
    vecs[15] = '{1'b1, A_TCFG,  32'h0000_0000, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b1, A_TVAL,  32'h0000_0000, 1'b0, 2'b00};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_has_int", {31'h0, has_int}, 32'h0);
    check("rst_lie", {30'h0, csr_ecfg_lie_soft}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    read_chk("rst_ecfg", A_ECFG, 32'h0);
    read_chk("rst_estat", A_ESTAT, 32'h0);
    read_chk("rst_tid", A_TID, TID_RST);
    read_chk("rst_tcfg", A_TCFG, 32'h0);
    read_chk("rst_tval", A_TVAL, 32'h0);

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      csr.csr_we    = vecs[i].we;
      csr.csr_addr  = vecs[i].addr;
      csr.csr_wdata = vecs[i].wdata;
      csr.csr_wmask = vecs[i].wmask;
      hw_int_in     = vecs[i].hw;
      ipi_int_in    = vecs[i].ipi;
      crmd_ie       = vecs[i].ie;
      @(posedge clk);
      #1;
      csr.csr_we    = 1'b0;
      csr.csr_raddr = vecs[i].raddr;
      #1;
      check($sformatf("vec%0d_rdata", i), csr.csr_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_has_int", i), {31'h0, has_int}, {31'h0, vecs[i].exp_int});
      check($sformatf("vec%0d_lie", i), {30'h0, csr_ecfg_lie_soft}, {30'h0, vecs[i].exp_lie});
    end

    // One-shot timer: InitVal=2 -> 8 down to 0, then IS[11] latches
    do_write(A_TCFG, 32'h0000_0009, 32'hFFFF_FFFF);
    read_chk("oneshot_load", A_TVAL, 32'd8);
    for (int k = 7; k >= 0; k--) begin
      tick();
      read_chk($sformatf("oneshot_tval%0d", k), A_TVAL, k);
      if (k > 0) read_bit_chk("oneshot_is11_early", A_ESTAT, 11, 1'b0);
    end
    tick();
    read_bit_chk("oneshot_is11_set", A_ESTAT, 11, 1'b1);
    read_chk("oneshot_hold0", A_TVAL, 32'h0);
    repeat (3) tick();
    read_chk("oneshot_still0", A_TVAL, 32'h0);
    do_write(A_TICLR, 32'h0000_0001, 32'hFFFF_FFFF);
    read_bit_chk("oneshot_ticlr", A_ESTAT, 11, 1'b0);
    repeat (4) tick();
    read_bit_chk("oneshot_no_reset", A_ESTAT, 11, 1'b0);

    // TICLR with bit0 masked off must not clear
    do_write(A_TCFG, 32'h0000_0001, 32'hFFFF_FFFF);
    tick();
    read_bit_chk("masked_ticlr_pre", A_ESTAT, 11, 1'b1);
    do_write(A_TICLR, 32'h0000_0001, 32'hFFFF_FFFE);
    read_bit_chk("masked_ticlr", A_ESTAT, 11, 1'b1);
    do_write(A_TICLR, 32'h0000_0001, 32'h0000_0001);
    read_bit_chk("masked_ticlr_clr", A_ESTAT, 11, 1'b0);

    // Periodic timer with a TICLR on the expiry cycle
    do_write(A_TCFG, 32'h0000_0007, 32'hFFFF_FFFF);
    read_chk("periodic_load", A_TVAL, 32'd4);
    for (int k = 3; k >= 0; k--) begin
      tick();
      read_chk($sformatf("periodic_tval%0d", k), A_TVAL, k);
    end
    do_write(A_TICLR, 32'h0000_0001, 32'hFFFF_FFFF);
    read_bit_chk("periodic_set_wins", A_ESTAT, 11, 1'b1);
    read_chk("periodic_reload", A_TVAL, 32'd4);
    tick();
    read_chk("periodic_count3", A_TVAL, 32'd3);
    do_write(A_TCFG, 32'h0000_0000, 32'hFFFF_FFFF);
    do_write(A_TICLR, 32'h0000_0001, 32'hFFFF_FFFF);
    repeat (6) tick();
    read_bit_chk("periodic_stopped", A_ESTAT, 11, 1'b0);

    // TCFG write colliding with expiry: new load wins, IS[11] still set
    do_write(A_TCFG, 32'h0000_0001, 32'hFFFF_FFFF);
    do_write(A_TCFG, 32'h0000_000D, 32'hFFFF_FFFF);
    read_chk("collide_load", A_TVAL, 32'd12);
    read_bit_chk("collide_is11", A_ESTAT, 11, 1'b1);
    tick();
    read_chk("collide_count", A_TVAL, 32'd11);
    do_write(A_TCFG, 32'h0000_0000, 32'hFFFF_FFFF);
    do_write(A_TICLR, 32'h0000_0001, 32'hFFFF_FFFF);

    // Exception commit alongside a concurrent IS write
    @(negedge clk);
    wb_ex         = 1'b1;
    wb_ecode      = 6'h0B;
    wb_esubcode   = 9'h000;
    csr.csr_we    = 1'b1;
    csr.csr_addr  = A_ESTAT;
    csr.csr_wdata = 32'h0000_0001;
    csr.csr_wmask = 32'hFFFF_FFFF;
    tick();
    wb_ex      = 1'b0;
    csr.csr_we = 1'b0;
    read_chk("ex_ecode", A_ESTAT, 32'h000B_0001);
    @(negedge clk);
    wb_ex       = 1'b1;
    wb_ecode    = 6'h3F;
    wb_esubcode = 9'h1FF;
    tick();
    wb_ex = 1'b0;
    read_chk("ex_esubcode", A_ESTAT, 32'h7FFF_0001);
    tick();
    read_chk("ex_hold", A_ESTAT, 32'h7FFF_0001);

    // Reset mid-count
    do_write(A_ECFG, 32'h0000_0003, 32'hFFFF_FFFF);
    crmd_ie = 1'b1;
    do_write(A_TCFG, 32'h0000_0401, 32'hFFFF_FFFF);
    repeat (3) tick();
    read_chk("midcount_tval", A_TVAL, 32'h0000_03FD);
    check("pre_rst_has_int", {31'h0, has_int}, 32'h1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("async_rst_has_int", {31'h0, has_int}, 32'h0);
    check("async_rst_lie", {30'h0, csr_ecfg_lie_soft}, 32'h0);
    read_chk("async_rst_tval", A_TVAL, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) tick();
    read_chk("post_rst_ecfg", A_ECFG, 32'h0);
    read_chk("post_rst_estat", A_ESTAT, 32'h0);
    read_chk("post_rst_tid", A_TID, TID_RST);
    read_chk("post_rst_tcfg", A_TCFG, 32'h0);
    read_chk("post_rst_tval", A_TVAL, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
